ram_bist: RTL and testbench
===========================

# ram_bist

Built-in self-test controller that drives the initiator side of the single-port `ram` (1024 × 8, synchronous write, registered read) and checks its contents. On a `start` pulse it runs a March-style sequence over every address, compares each read against the expected pattern, and reports pass/fail with the first failing address and data. It sits between the board control logic (buttons and LEDs) and the `ram` instance, owning `write_enable`, `address` and `data_in` while it is busy.

## Interface
- `ADDR_WIDTH`, 10, RAM address width; depth is 2^ADDR_WIDTH.
- `DATA_WIDTH`, 8, RAM data width.
- `BG`, 8'h55, background pattern; only the low DATA_WIDTH bits are used.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin the test; sampled only in IDLE or DONE.
- `busy` out 1: test in progress.
- `done` out 1: level, held from test end until the next accepted `start`.
- `pass` out 1: valid while `done`=1; 1 means no mismatch.
- `fail_addr` out ADDR_WIDTH: address of the first mismatch.
- `fail_data` out DATA_WIDTH: read data at the first mismatch.
- `ram_we` out 1: to `ram.write_enable`.
- `ram_addr` out ADDR_WIDTH: to `ram.address`.
- `ram_wdata` out DATA_WIDTH: to `ram.data_in`.
- `ram_rdata` in DATA_WIDTH: from `ram.data_out`.

## Operation
- Expected pattern: P(a) = BG ^ a[DATA_WIDTH-1:0]. The complement phase uses ~P(a). Mixing the address into the pattern exposes aliasing faults.
- FSM states: IDLE → W0 → R0 ↔ W1 → R1 → DRAIN → DONE. All outputs are registered.
  - **W0:** write P(a) for a = 0 … max, ascending, one address per cycle.
  - **R0/W1:** for each ascending a, read a (expect P(a)), then write ~P(a) to a in the next cycle.
  - **R1:** read a = 0 … max, ascending, expecting ~P(a).
  - **DRAIN:** one cycle, `ram_we`=0, to compare the final read.
  - **DONE:** `busy`=0, `done`=1. A `start` here restarts at W0.
- Compare pipeline: each read registers its address and expected value. The compare happens at the next edge, when `ram_rdata` is valid.
- First mismatch: clear `pass`, capture `fail_addr`/`fail_data`. Later mismatches do not overwrite the capture.
- On an accepted `start`: `pass` is set to 1, `done` cleared, `fail_*` cleared.
- `start` while `busy` is ignored.
- Address counter: it is ADDR_WIDTH bits and wraps at max. The phase change is decided on `ram_addr == 2^ADDR_WIDTH-1`, never on the wrap itself.
- `ram_we`=0 and `ram_addr`/`ram_wdata` hold their last values in IDLE and DONE.

## Timing
- Reset values: `busy` 0, `done` 0, `pass` 0, `fail_addr` 0, `fail_data` 0, `ram_we` 0, `ram_addr` 0, `ram_wdata` 0; state IDLE.
- Reset mid-test: all outputs return to their reset values immediately (asynchronously), and `ram_we` drops without waiting for a clock edge. There is no resume; a new `start` is needed.
- Start: `start` sampled high at edge E. At E: `busy`=1, `ram_we`=1, `ram_addr`=0, `ram_wdata`=P(0).
- Phase lengths:
  - W0: 2^A cycles.
  - R0/W1: 2·2^A cycles.
  - R1: 2^A cycles.
  - DRAIN: 1 cycle.
- `busy` is high for exactly 4·2^A+1 cycles (4097 at defaults). `done`, `pass` and `fail_*` are valid from the edge where `busy` falls.
- The read in the R0 cycle for address a is compared at the edge that ends the following W1 cycle. The W1 write to a commits at that same edge; the read data was already captured.

## Configuration
- Macro: `RAM_BIST_STOP_ON_FAIL_EN`.
- Defined: at the compare edge that detects the first mismatch, the FSM goes straight to DONE. `busy`=0, `done`=1, `pass`=0 and `ram_we`=0 all take effect from that edge, and no further RAM writes occur.
- Undefined: the sequence always runs its full 4·2^A+1 cycles. Only the first failure is recorded.

## Test plan
All scenarios use a behavioural RAM model with 1-cycle registered read and default parameters.
- **Fault-free RAM:** one-cycle `start` → `busy` high for 4097 cycles, then `done`=1, `pass`=1, `fail_addr`=0, `fail_data`=0.
- **Stuck-at-1 on bit 0 at address 50:** R0 reads 0x67 and passes; R1 reads 0x99 against expected 0x98 → `pass`=0, `fail_addr`=50, `fail_data`=0x99, run length 4097 cycles.
- **Aliasing, writes to 1023 land on address 0:** the W0 write of 0xAA overwrites address 0 → R0 mismatch at address 0: `fail_addr`=0, `fail_data`=0xAA, expected 0x55.
- **Reset mid-test:** `rst_n` low at cycle 2000 → `ram_we`, `busy` and `done` go to 0 asynchronously. A fresh `start` then completes with `pass`=1 after 4097 cycles.
- **`start` while busy, then restart:** `start` pulsed at cycle 100 has no effect. After `done`, a new `start` clears `done` and reruns for 4097 cycles.
- **With `RAM_BIST_STOP_ON_FAIL_EN`:** the aliasing fault → `done`=1 at the edge after the W1 cycle for address 0 (cycle 1024+2 from `start`). `ram_we`=0 from that edge, `fail_addr`=0.

Source files
------------

// File: rtl/ram_bist.sv
// ram_bist: March-style built-in self-test controller for a single-port RAM
// with synchronous write and registered (1-cycle) read.
// Sequence: W0 (write P) -> R0/W1 (read P, write ~P) -> R1 (read ~P) -> DRAIN.
// P(a) = BG ^ a, truncated or zero-extended to DATA_WIDTH.
// Optional feature macro: RAM_BIST_STOP_ON_FAIL_EN -- when defined, the test
// ends at the compare edge that detects the first mismatch.
module ram_bist #(
    parameter int unsigned           ADDR_WIDTH = 10,
    parameter int unsigned           DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] BG         = 8'h55
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_data,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_W0,
        S_R0,
        S_W1,
        S_R1,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                r_state;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_pass;
    logic [ADDR_WIDTH-1:0] r_fail_addr;
    logic [DATA_WIDTH-1:0] r_fail_data;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;

    // Compare pipeline: a read issued in cycle N is checked at the end of N+1
    logic                  r_cmp_vld;
    logic [ADDR_WIDTH-1:0] r_cmp_addr;
    logic [DATA_WIDTH-1:0] r_cmp_exp;

    logic                  w_addr_last;
    logic [ADDR_WIDTH-1:0] w_addr_next;
    logic                  w_first_fail;

    function automatic logic [DATA_WIDTH-1:0] pat(input logic [ADDR_WIDTH-1:0] a);
        return BG ^ DATA_WIDTH'(a);
    endfunction

    // Phase changes are decided on the last address, never on the wrap
    assign w_addr_last  = (r_addr == '1);
    assign w_addr_next  = r_addr + ADDR_WIDTH'(1);
    // r_pass stays 1 during a run until the first mismatch is captured
    assign w_first_fail = r_cmp_vld && (ram_rdata != r_cmp_exp) && r_pass;

    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign fail_addr = r_fail_addr;
    assign fail_data = r_fail_data;
    assign ram_we    = r_we;
    assign ram_addr  = r_addr;
    assign ram_wdata = r_wdata;

    // Test sequencer, RAM drive, and first-mismatch capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_data <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cmp_vld   <= 1'b0;
            r_cmp_addr  <= '0;
            r_cmp_exp   <= '0;
        end else begin
            r_cmp_vld <= 1'b0;

            if (w_first_fail) begin
                r_pass      <= 1'b0;
                r_fail_addr <= r_cmp_addr;
                r_fail_data <= ram_rdata;
            end

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state     <= S_W0;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b1;
                        r_fail_addr <= '0;
                        r_fail_data <= '0;
                        r_we        <= 1'b1;
                        r_addr      <= '0;
                        r_wdata     <= pat('0);
                    end
                end
                S_W0: begin
                    if (w_addr_last) begin
                        r_state <= S_R0;
                        r_we    <= 1'b0;
                        r_addr  <= '0;
                    end else begin
                        r_addr  <= w_addr_next;
                        r_wdata <= pat(w_addr_next);
                    end
                end
                S_R0: begin
                    r_cmp_vld  <= 1'b1;
                    r_cmp_addr <= r_addr;
                    r_cmp_exp  <= pat(r_addr);
                    r_state    <= S_W1;
                    r_we       <= 1'b1;
                    r_wdata    <= ~pat(r_addr);
                end
                S_W1: begin
                    r_we <= 1'b0;
                    if (w_addr_last) begin
                        r_state <= S_R1;
                        r_addr  <= '0;
                    end else begin
                        r_state <= S_R0;
                        r_addr  <= w_addr_next;
                    end
                end
                S_R1: begin
                    r_cmp_vld  <= 1'b1;
                    r_cmp_addr <= r_addr;
                    r_cmp_exp  <= ~pat(r_addr);
                    if (w_addr_last) begin
                        r_state <= S_DRAIN;
                    end else begin
                        r_addr  <= w_addr_next;
                    end
                end
                S_DRAIN: begin
                    r_state <= S_DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

`ifdef RAM_BIST_STOP_ON_FAIL_EN
            // Abort overrides whatever the sequencer chose at this edge
            if (w_first_fail) begin
                r_state   <= S_DONE;
                r_busy    <= 1'b0;
                r_done    <= 1'b1;
                r_we      <= 1'b0;
                r_cmp_vld <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_ram_bist.sv
// Self-checking bench for ram_bist with a behavioural 1024x8 RAM (registered
// read) that can inject a stuck-at bit or a write-alias fault. Expected
// results come from an array-based model of the March algorithm.
module tb_ram_bist;

`ifdef RAM_BIST_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif
    localparam int FULL_LEN = 4097;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       busy;
    logic       done;
    logic       pass;
    logic [9:0] fail_addr;
    logic [7:0] fail_data;
    logic       ram_we;
    logic [9:0] ram_addr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    // fault configuration for the RAM model
    bit   f_sa_en    = 0;
    int   f_sa_addr  = 0;
    int   f_sa_bit   = 0;
    bit   f_sa_val   = 0;
    bit   f_alias_en = 0;
    logic mem_clr    = 0;

    logic [7:0] mem [1024];

    // first-cycle snapshot taken by do_run
    logic       s_busy, s_done, s_pass, s_we;
    logic [9:0] s_addr, s_fa;
    logic [7:0] s_wdata, s_fd;

    ram_bist #(
        .ADDR_WIDTH(10),
        .DATA_WIDTH(8),
        .BG        (8'h55)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .fail_addr(fail_addr),
        .fail_data(fail_data),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] tb_pat(input int a);
        return 8'h55 ^ 8'(a % 256);
    endfunction

    function automatic int tb_wmap(input int a);
        return (f_alias_en && a == 1023) ? 0 : a;
    endfunction

    function automatic logic [7:0] tb_fault_rd(input logic [7:0] v, input int a);
        logic [7:0] r;
        r = v;
        if (f_sa_en && a == f_sa_addr) r[f_sa_bit] = f_sa_val;
        return r;
    endfunction

    // behavioural RAM: synchronous write, registered read of old contents
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
        end else if (ram_we) begin
            mem[tb_wmap(int'(ram_addr))] <= ram_wdata;
        end
        ram_rdata <= tb_fault_rd(mem[ram_addr], int'(ram_addr));
    end

    // March model: returns first failure and the run length in cycles
    task automatic model_run(output logic exp_pass, output logic [9:0] exp_fa,
                             output logic [7:0] exp_fd, output int exp_len);
        logic [7:0] m [1024];
        logic [7:0] rd;
        int fail_edge;
        for (int i = 0; i < 1024; i++) m[i] = 8'h00;
        exp_pass = 1'b1; exp_fa = '0; exp_fd = '0; fail_edge = FULL_LEN;
        for (int a = 0; a < 1024; a++) m[tb_wmap(a)] = tb_pat(a);
        for (int a = 0; a < 1024; a++) begin
            rd = tb_fault_rd(m[a], a);
            if (exp_pass && rd !== tb_pat(a)) begin
                exp_pass = 1'b0; exp_fa = 10'(a); exp_fd = rd;
                fail_edge = 1024 + 2 * a + 2;
            end
            m[tb_wmap(a)] = ~tb_pat(a);
        end
        for (int a = 0; a < 1024; a++) begin
            rd = tb_fault_rd(m[a], a);
            if (exp_pass && rd !== ~tb_pat(a)) begin
                exp_pass = 1'b0; exp_fa = 10'(a); exp_fd = rd;
                fail_edge = 3072 + a + 2;
            end
        end
        exp_len = STOP ? fail_edge : FULL_LEN;
    endtask

    // clears the RAM, pulses start, counts busy cycles (bounded);
    // optionally pulses start again at busy cycle inj
    task automatic do_run(input int inj, output int cycles);
        @(negedge clk); mem_clr = 1'b1;
        @(negedge clk); mem_clr = 1'b0;
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        s_busy = busy; s_done = done; s_pass = pass; s_we = ram_we;
        s_addr = ram_addr; s_wdata = ram_wdata; s_fa = fail_addr; s_fd = fail_data;
        cycles = 0;
        while (busy === 1'b1 && cycles < 6000) begin
            cycles++;
            start = (cycles == inj);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (pass !== 1'b0) begin n_fail++; $display("FAIL reset_pass: got %b expected 0", pass); end
        n_checks++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b expected 0", ram_we); end
        n_checks++; if ({fail_addr, fail_data, ram_addr, ram_wdata} !== 36'h0) begin
            n_fail++; $display("FAIL reset_vectors: got fa=%h fd=%h addr=%h wd=%h expected all 0",
                               fail_addr, fail_data, ram_addr, ram_wdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fault_free;
        int cyc;
        f_sa_en = 0; f_alias_en = 0;
        do_run(0, cyc);
        n_checks++; if (s_busy !== 1'b1 || s_done !== 1'b0 || s_pass !== 1'b1) begin
            n_fail++; $display("FAIL start_flags: got busy=%b done=%b pass=%b expected 1 0 1", s_busy, s_done, s_pass);
        end
        n_checks++; if (s_we !== 1'b1 || s_addr !== 10'd0 || s_wdata !== 8'h55) begin
            n_fail++; $display("FAIL start_drive: got we=%b addr=%h wd=%h expected 1 000 55", s_we, s_addr, s_wdata);
        end
        n_checks++; if (cyc !== FULL_LEN) begin n_fail++; $display("FAIL ff_len: got %0d expected %0d", cyc, FULL_LEN); end
        n_checks++; if (done !== 1'b1 || pass !== 1'b1) begin
            n_fail++; $display("FAIL ff_result: got done=%b pass=%b expected 1 1", done, pass);
        end
        n_checks++; if (fail_addr !== 10'd0 || fail_data !== 8'd0) begin
            n_fail++; $display("FAIL ff_failinfo: got %h/%h expected 000/00", fail_addr, fail_data);
        end
        n_checks++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL ff_done_we: got %b expected 0", ram_we); end
    endtask

    task automatic run_fault_case(input string name);
        int cyc, exp_len;
        logic exp_pass;
        logic [9:0] exp_fa;
        logic [7:0] exp_fd;
        model_run(exp_pass, exp_fa, exp_fd, exp_len);
        do_run(0, cyc);
        n_checks++; if (cyc !== exp_len) begin n_fail++; $display("FAIL %s_len: got %0d expected %0d", name, cyc, exp_len); end
        n_checks++; if (done !== 1'b1 || pass !== exp_pass) begin
            n_fail++; $display("FAIL %s_result: got done=%b pass=%b expected 1 %b", name, done, pass, exp_pass);
        end
        n_checks++; if (fail_addr !== exp_fa || fail_data !== exp_fd) begin
            n_fail++; $display("FAIL %s_failinfo: got %0d/%h expected %0d/%h", name, fail_addr, fail_data, exp_fa, exp_fd);
        end
        n_checks++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL %s_done_we: got %b expected 0", name, ram_we); end
    endtask

    task automatic test_stuck_at;
        f_alias_en = 0; f_sa_en = 1; f_sa_addr = 50; f_sa_bit = 0; f_sa_val = 1;
        run_fault_case("stuck50");
        n_checks++; if (fail_addr !== 10'd50 || fail_data !== 8'h99) begin
            n_fail++; $display("FAIL stuck50_const: got %0d/%h expected 50/99", fail_addr, fail_data);
        end
        f_sa_en = 0;
    endtask

    task automatic test_alias;
        f_sa_en = 0; f_alias_en = 1;
        run_fault_case("alias");
        n_checks++; if (fail_addr !== 10'd0 || fail_data !== 8'hAA) begin
            n_fail++; $display("FAIL alias_const: got %0d/%h expected 0/aa", fail_addr, fail_data);
        end
        f_alias_en = 0;
    endtask

    task automatic test_random_faults;
        for (int k = 0; k < 3; k++) begin
            f_alias_en = 0; f_sa_en = 1;
            f_sa_addr = int'($urandom_range(0, 1023));
            f_sa_bit  = int'($urandom_range(0, 7));
            f_sa_val  = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run_fault_case("rand_sa");
        end
        f_sa_en = 0;
    endtask

    task automatic test_back_to_back;
        int cyc;
        f_sa_en = 0; f_alias_en = 0;
        // previous run ended with a recorded failure; a new start must clear it
        do_run(100, cyc);
        n_checks++; if (s_pass !== 1'b1 || s_done !== 1'b0 || s_fa !== 10'd0 || s_fd !== 8'd0) begin
            n_fail++; $display("FAIL restart_clear: got pass=%b done=%b fa=%h fd=%h expected 1 0 000 00", s_pass, s_done, s_fa, s_fd);
        end
        n_checks++; if (cyc !== FULL_LEN) begin n_fail++; $display("FAIL busy_start_len: got %0d expected %0d", cyc, FULL_LEN); end
        n_checks++; if (pass !== 1'b1 || done !== 1'b1) begin
            n_fail++; $display("FAIL busy_start_result: got pass=%b done=%b expected 1 1", pass, done);
        end
        do_run(0, cyc);
        n_checks++; if (s_done !== 1'b0 || s_busy !== 1'b1) begin
            n_fail++; $display("FAIL rerun_start: got done=%b busy=%b expected 0 1", s_done, s_busy);
        end
        n_checks++; if (cyc !== FULL_LEN || pass !== 1'b1) begin
            n_fail++; $display("FAIL rerun_result: got len=%0d pass=%b expected %0d 1", cyc, pass, FULL_LEN);
        end
    endtask

    task automatic test_reset_mid;
        int cyc;
        f_sa_en = 0; f_alias_en = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (2001) @(negedge clk);
        n_checks++; if (busy !== 1'b1 || ram_we !== 1'b1) begin
            n_fail++; $display("FAIL mid_pre: got busy=%b we=%b expected 1 1", busy, ram_we);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0 || ram_we !== 1'b0 || pass !== 1'b0) begin
            n_fail++; $display("FAIL mid_async: got busy=%b done=%b we=%b pass=%b expected 0 0 0 0", busy, done, ram_we, pass);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++; if (busy !== 1'b0 || ram_we !== 1'b0) begin
            n_fail++; $display("FAIL mid_no_resume: got busy=%b we=%b expected 0 0", busy, ram_we);
        end
        do_run(0, cyc);
        n_checks++; if (cyc !== FULL_LEN || pass !== 1'b1 || done !== 1'b1) begin
            n_fail++; $display("FAIL mid_rerun: got len=%0d pass=%b done=%b expected %0d 1 1", cyc, pass, done, FULL_LEN);
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        test_reset;
        test_fault_free;
        test_stuck_at;
        test_alias;
        test_back_to_back;
        test_reset_mid;
        test_random_faults;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
